nibble_serial_subtractor_16: RTL and testbench

NIBBLE_SERIAL_SUBTRACTOR_16 -- requirements
Module: nibble_serial_subtractor_16

---
 rtl/nibble_serial_subtractor_16_pkg.sv | 12 +
 rtl/nibble_serial_subtractor_16_sub_slice_4bit.sv | 28 ++
 rtl/nibble_serial_subtractor_16.sv | 104 ++++++++++
 tb/tb_nibble_serial_subtractor_16.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_16_pkg.sv
// Shared sizing constants and FSM encoding for the nibble-serial subtractor.
package nibble_serial_subtractor_16_pkg;
  localparam int WIDTH   = 16;
  localparam int SLICE   = 4;
  localparam int NIBBLES = WIDTH / SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/nibble_serial_subtractor_16_sub_slice_4bit.sv
// Combinational 4-bit carry-look-ahead slice: sum = a + ~b + cin.
module sub_slice_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] w_bn, w_g, w_p;
  logic [4:0] w_c;

  assign w_bn = ~b;
  assign w_g  = a & w_bn;
  assign w_p  = a ^ w_bn;

  // Flat look-ahead carries, no ripple between bit positions
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum  = w_p ^ w_c[3:0];
  assign cout = w_c[4];
endmodule

// File: rtl/nibble_serial_subtractor_16.sv
// 16-bit subtractor computing a - b - bin one nibble per cycle, LSB first,
// with a valid/ready handshake on both sides and one transaction in flight.
module nibble_serial_subtractor_16
  import nibble_serial_subtractor_16_pkg::*;
#(
  parameter int WIDTH = nibble_serial_subtractor_16_pkg::WIDTH,
  parameter int SLICE = nibble_serial_subtractor_16_pkg::SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam logic [1:0] LAST = 2'(NIBBLES - 1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic             r_a_msb, r_b_msb;
  logic             r_carry;
  logic [1:0]       r_cnt;
  logic             r_bout, r_ovf, r_zero;

  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_diff_nxt;

  sub_slice_4bit u_slice (
    .a    (r_a[SLICE-1:0]),
    .b    (r_b[SLICE-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // New nibble enters at the top so after the last step diff is in place
  assign w_diff_nxt = {w_sum, r_diff[WIDTH-1:SLICE]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)       w_state_nxt = RUN;
      RUN:     if (r_cnt == LAST)  w_state_nxt = DONE;
      DONE:    if (out_ready)      w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= 2'd0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_a     <= a;
      r_b     <= b;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_carry <= ~bin;
      r_cnt   <= 2'd0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> SLICE;
      r_b     <= r_b >> SLICE;
      r_diff  <= w_diff_nxt;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 2'd1;
      if (r_cnt == LAST) begin
        r_bout <= ~w_cout;
        r_ovf  <= (r_a_msb != r_b_msb) && (w_sum[SLICE-1] != r_a_msb);
        r_zero <= (w_diff_nxt == '0);
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
endmodule

// File: tb/tb_nibble_serial_subtractor_16.sv
// Directed-vector and randomised checks of the nibble-serial subtractor.
module tb_nibble_serial_subtractor_16;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b, diff;
  logic        bin, out_valid, out_ready, bout, ovf, zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor_16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns the observed result; operands are scrambled right after acceptance
  // and extra in_valid is driven while stalled in DONE.
  task automatic do_txn(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                        input int stall, input bit chk_lat,
                        output logic [15:0] rd, output logic rbo, output logic rov,
                        output logic rz);
    int lat;
    bit hold_ok;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_; bin = tbin; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_; bin = ~tbin;
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 20) break;
      @(posedge clk);
      lat++;
    end
    if (!out_valid) begin
      chk("result_timeout", 32'(out_valid), 32'd1);
      rd = 'x; rbo = 1'bx; rov = 1'bx; rz = 1'bx;
      return;
    end
    if (chk_lat) chk("latency_edges", 32'(lat), 32'd4);
    rd = diff; rbo = bout; rov = ovf; rz = zero;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; a = 16'h1111; b = 16'h2222; bin = 1'b1;
      @(negedge clk);
      hold_ok = (diff === rd) && (bout === rbo) && (ovf === rov) && (zero === rz)
                && out_valid && !in_ready;
      chk("stall_hold", 32'(hold_ok), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic vec_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
    vec_t v;
    logic [16:0] full;
    int s;
    full = {1'b0, ta} - {1'b0, tb_} - {16'd0, tbin};
    s = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
    v.a = ta; v.b = tb_; v.bin = tbin;
    v.diff = full[15:0];
    v.bout = full[16];
    v.ovf  = (s > 32767) || (s < -32768);
    v.zero = (full[15:0] == 16'd0);
    return v;
  endfunction

  initial begin
    logic [15:0] rd;
    logic rbo, rov, rz;
    vec_t m;
    bit pulse;

    //          a         b         bin   diff      bout  ovf   zero
    vecs.push_back('{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0});

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_results", {12'd0, diff, bout, ovf, zero, 1'b0}, 32'd0);

    foreach (vecs[i]) begin
      do_txn(vecs[i].a, vecs[i].b, vecs[i].bin, (i == 0) ? 10 : 0, 1'b1, rd, rbo, rov, rz);
      chk($sformatf("vec%0d_diff", i), 32'(rd), 32'(vecs[i].diff));
      chk($sformatf("vec%0d_bout", i), 32'(rbo), 32'(vecs[i].bout));
      chk($sformatf("vec%0d_ovf", i), 32'(rov), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_zero", i), 32'(rz), 32'(vecs[i].zero));
    end

    // Abort in the second RUN cycle; nothing may come out afterwards
    @(negedge clk);
    in_valid = 1'b1; a = 16'h8000; b = 16'h0001; bin = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_outputs", {12'd0, diff, bout, ovf, zero, out_valid}, 32'd0);
    pulse = 1'b0;
    repeat (6) begin
      @(negedge clk);
      pulse |= out_valid;
    end
    chk("abort_no_pulse", 32'(pulse), 32'd0);
    do_txn(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b1, rd, rbo, rov, rz);
    chk("post_abort_diff", 32'(rd), 32'h0000FFFF);
    chk("post_abort_bout", 32'(rbo), 32'd1);

    // out_ready high while still computing must not cut the run short
    @(negedge clk);
    in_valid = 1'b1; a = 16'h00F0; b = 16'h000F; bin = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("early_ready_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("early_ready_valid", 32'(out_valid), 32'd1);
    chk("early_ready_diff", 32'(diff), 32'h000000E1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("early_ready_released", 32'(in_ready), 32'd1);

    for (int n = 0; n < 2000; n++) begin
      logic [15:0] ra, rb;
      logic rbin;
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (n % 7 == 0) rb = ra;
      m = model(ra, rb, rbin);
      do_txn(ra, rb, rbin, $urandom_range(0, 3), 1'b0, rd, rbo, rov, rz);
      chk("rand_result", {13'd0, rd, rbo, rov, rz}, {13'd0, m.diff, m.bout, m.ovf, m.zero});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
